// File: rtl/gate_response_checker.sv
// gate_response_checker
// Receive-side checker for the AND/OR/NOT/XOR gate block. Accepts one
// stimulus vector per valid/ready handshake, waits SETTLE_CYCLES clocks,
// samples the four gate outputs and compares them with a golden model.
// Tallies vectors and mismatches, captures the first failing vector and
// reports pass/fail once the vector flagged as last has been checked.
// Optional feature macro: COVERAGE_EN (adds cov_map_o/cov_full_o and makes
// pass additionally require full input-combination coverage).

module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             vec_vld_i,
  output logic             vec_rdy_o,
  input  logic             vec_last_i,
  input  logic             aa_i,
  input  logic             bb_i,
  input  logic             cc_i,
  input  logic             out1_i,
  input  logic             out2_i,
  input  logic             out3_i,
  input  logic             out4_i,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [6:0]       first_err_o,
  output logic             chk_done_o,
  output logic             chk_pass_o
`ifdef COVERAGE_EN
  ,
  output logic [7:0]       cov_map_o,
  output logic             cov_full_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  // Golden model of the gate block: {out1,out2,out3,out4}.
  function automatic logic [3:0] golden(input logic [2:0] vin);
    logic a, b, c;
    a = vin[2];
    b = vin[1];
    c = vin[0];
    golden = {a & b, a | b, ~c, a ^ b ^ c};
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         settle_q, settle_d;
  logic [2:0]         vin_q, vin_d;
  logic               last_q, last_d;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [6:0]         first_err_q, first_err_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [7:0]         cov_q, cov_d;
  logic               cov_full_q, cov_full_d;
  logic [3:0]         outs_s;
  logic               mismatch_s;
  logic               xfer_s;

  assign outs_s     = {out1_i, out2_i, out3_i, out4_i};
  // Four-state compare so X/Z on the gate outputs reads as a mismatch.
  assign mismatch_s = (outs_s !== golden(vin_q));
  assign xfer_s     = vec_vld_i && rdy_q;

  // Next-state, counter, capture and ready logic.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    vin_d       = vin_q;
    last_d      = last_q;
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    done_d      = done_q;
    pass_d      = pass_q;
    cov_d       = cov_q;
    cov_full_d  = cov_full_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          vin_d    = {aa_i, bb_i, cc_i};
          last_d   = vec_last_i;
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == 8'd0) begin
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      ST_CHECK: begin
        vec_cnt_d  = sat_inc(vec_cnt_q);
        cov_d      = cov_q | (8'd1 << vin_q);
        cov_full_d = &cov_d;
        if (mismatch_s) begin
          err_cnt_d = sat_inc(err_cnt_q);
          if (err_cnt_q == {CNT_W{1'b0}}) begin
            first_err_d = {vin_q, outs_s};
          end else begin
            first_err_d = first_err_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if (last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
`ifdef COVERAGE_EN
          pass_d  = (err_cnt_d == {CNT_W{1'b0}}) && cov_full_d;
`else
          pass_d  = (err_cnt_d == {CNT_W{1'b0}});
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      settle_q    <= 8'd0;
      vin_q       <= 3'd0;
      last_q      <= 1'b0;
      rdy_q       <= 1'b0;
      vec_cnt_q   <= {CNT_W{1'b0}};
      err_cnt_q   <= {CNT_W{1'b0}};
      first_err_q <= 7'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      cov_q       <= 8'd0;
      cov_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      vin_q       <= vin_d;
      last_q      <= last_d;
      rdy_q       <= rdy_d;
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      cov_q       <= cov_d;
      cov_full_q  <= cov_full_d;
    end
  end

  assign vec_rdy_o   = rdy_q;
  assign vec_cnt_o   = vec_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign first_err_o = first_err_q;
  assign chk_done_o  = done_q;
  assign chk_pass_o  = pass_q;
`ifdef COVERAGE_EN
  assign cov_map_o   = cov_q;
  assign cov_full_o  = cov_full_q;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Testbench for gate_response_checker: a cycle-level behavioural model of the
// checker, compared against the DUT on every falling edge, plus directed
// scenarios with hand-computed literal expectations.

module tb_gate_response_checker;

  localparam int S    = 4;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, vld, last, aa, bb, cc, fault4;
  logic o1, o2, o3, o4;
  logic rdy, done, pass;
  logic [7:0] vcnt, ecnt;
  logic [6:0] ferr;
  logic s_vld, s_last, s_o1, s_o2, s_o3, s_o4, s_rdy, s_done, s_pass;
  logic [1:0] s_vcnt, s_ecnt;
  logic [6:0] s_ferr;
`ifdef COVERAGE_EN
  logic [7:0] cov_map, s_cov_map;
  logic cov_full, s_cov_full;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Gate block stand-in, with an optional stuck-at-0 on out4.
  always_comb begin
    o1 = aa & bb;
    o2 = aa | bb;
    o3 = ~cc;
    o4 = fault4 ? 1'b0 : (aa ^ bb ^ cc);
  end

  // Fully broken gate block for the saturation instance.
  always_comb begin
    s_o1 = ~(aa & bb);
    s_o2 = ~(aa | bb);
    s_o3 = cc;
    s_o4 = ~(aa ^ bb ^ cc);
  end

  gate_response_checker #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .vec_vld_i(vld), .vec_rdy_o(rdy),
    .vec_last_i(last), .aa_i(aa), .bb_i(bb), .cc_i(cc),
    .out1_i(o1), .out2_i(o2), .out3_i(o3), .out4_i(o4),
    .vec_cnt_o(vcnt), .err_cnt_o(ecnt), .first_err_o(ferr),
    .chk_done_o(done), .chk_pass_o(pass)
`ifdef COVERAGE_EN
    , .cov_map_o(cov_map), .cov_full_o(cov_full)
`endif
  );

  gate_response_checker #(.SETTLE_CYCLES(1), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .vec_vld_i(s_vld), .vec_rdy_o(s_rdy),
    .vec_last_i(s_last), .aa_i(aa), .bb_i(bb), .cc_i(cc),
    .out1_i(s_o1), .out2_i(s_o2), .out3_i(s_o3), .out4_i(s_o4),
    .vec_cnt_o(s_vcnt), .err_cnt_o(s_ecnt), .first_err_o(s_ferr),
    .chk_done_o(s_done), .chk_pass_o(s_pass)
`ifdef COVERAGE_EN
    , .cov_map_o(s_cov_map), .cov_full_o(s_cov_full)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected gate outputs from the gate truth rules, via counting of ones.
  function automatic logic [3:0] expect_outs(input logic [2:0] v);
    int ab, ones;
    ab   = int'(v[2]) + int'(v[1]);
    ones = ab + int'(v[0]);
    return {ab == 2, ab > 0, v[0] == 1'b0, (ones % 2) == 1};
  endfunction

  function automatic bit mism(input logic [2:0] v, input logic [3:0] outs);
    return outs !== expect_outs(v);
  endfunction

  // Behavioural model state.
  int         cyc = 0;
  bit         m_rdy = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_pend = 1'b0, m_last = 1'b0;
  int         m_vcnt = 0, m_ecnt = 0, m_due = 0;
  logic [6:0] m_ferr = 7'd0;
  logic [2:0] m_vin = 3'd0;
  logic [7:0] m_cov = 8'd0;
  int         acc_q[$];

  // Model: one pending vector, checked S+1 edges after acceptance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_rdy <= 1'b0; m_vcnt <= 0; m_ecnt <= 0; m_ferr <= 7'd0;
      m_done <= 1'b0; m_pass <= 1'b0; m_pend <= 1'b0; m_cov <= 8'd0;
    end else if (m_pend) begin
      if (cyc == m_due) begin
        m_pend <= 1'b0;
        m_vcnt <= (m_vcnt < MAXC) ? m_vcnt + 1 : m_vcnt;
        m_cov  <= m_cov | (8'd1 << m_vin);
        if (mism(m_vin, {o1, o2, o3, o4})) begin
          m_ecnt <= (m_ecnt < MAXC) ? m_ecnt + 1 : m_ecnt;
          if (m_ecnt == 0) m_ferr <= {m_vin, o1, o2, o3, o4};
        end
        m_rdy  <= !m_last;
        m_done <= m_last;
`ifdef COVERAGE_EN
        m_pass <= (m_ecnt == 0) && !mism(m_vin, {o1, o2, o3, o4}) &&
                  ((m_cov | (8'd1 << m_vin)) == 8'hFF);
`else
        m_pass <= (m_ecnt == 0) && !mism(m_vin, {o1, o2, o3, o4});
`endif
      end
    end else if (m_rdy && vld) begin
      m_pend <= 1'b1;
      m_due  <= cyc + S + 1;
      m_vin  <= {aa, bb, cc};
      m_last <= last;
      m_rdy  <= 1'b0;
      acc_q.push_back(cyc);
    end else if (!m_done) begin
      m_rdy <= 1'b1;
    end
  end

  // Per-cycle compare of the main DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("vec_rdy", 32'(rdy), 32'(m_rdy));
      check("vec_cnt", 32'(vcnt), 32'(m_vcnt));
      check("err_cnt", 32'(ecnt), 32'(m_ecnt));
      check("first_err", 32'(ferr), 32'(m_ferr));
      check("chk_done", 32'(done), 32'(m_done));
      if (m_done) check("chk_pass", 32'(pass), 32'(m_pass));
`ifdef COVERAGE_EN
      check("cov_map", 32'(cov_map), 32'(m_cov));
      check("cov_full", 32'(cov_full), 32'(m_cov == 8'hFF));
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic send(input logic [2:0] v, input logic l, input bit wait_done);
    int n;
    @(negedge clk);
    {aa, bb, cc} = v; last = l; vld = 1'b1;
    n = 0;
    while (rdy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL accept_timeout: vec_rdy stayed %b", rdy); end
    @(negedge clk);
    vld = 1'b0; last = 1'b0;
    if (wait_done) begin
      n = 0;
      while (!(rdy === 1'b1 || done === 1'b1) && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin checks++; errors++; $display("FAIL check_timeout: no ready/done"); end
    end
  endtask

  task automatic send_s(input logic [2:0] v, input logic l);
    int n;
    @(negedge clk);
    {aa, bb, cc} = v; s_last = l; s_vld = 1'b1;
    n = 0;
    while (s_rdy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL sat_accept_timeout: vec_rdy stayed %b", s_rdy); end
    @(negedge clk);
    s_vld = 1'b0; s_last = 1'b0;
    n = 0;
    while (!(s_rdy === 1'b1 || s_done === 1'b1) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL sat_check_timeout: no ready/done"); end
  endtask

  logic [2:0] seq [7];

  initial begin
    int n;
    rst_n = 1'b0; vld = 1'b0; last = 1'b0; aa = 1'b0; bb = 1'b0; cc = 1'b0;
    fault4 = 1'b0; s_vld = 1'b0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_vec_cnt", 32'(vcnt), 32'd0);
    check("reset_err_cnt", 32'(ecnt), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Correct gate block, seven vectors.
    seq = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b110, 3'b111, 3'b110};
    for (int i = 0; i < 7; i++) send(seq[i], i == 6, 1'b1);
    repeat (2) @(negedge clk);
    check("seq_vec_cnt", 32'(vcnt), 32'd7);
    check("seq_err_cnt", 32'(ecnt), 32'd0);
    check("seq_done", 32'(done), 32'd1);
`ifdef COVERAGE_EN
    check("seq_pass", 32'(pass), 32'd0);
`else
    check("seq_pass", 32'(pass), 32'd1);
`endif
    check("seq_rdy_in_done", 32'(rdy), 32'd0);

    // Stuck-at-0 on out4.
    do_reset();
    fault4 = 1'b1;
    send(3'b100, 1'b0, 1'b1);
    send(3'b110, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("sa0_err_cnt", 32'(ecnt), 32'd1);
    check("sa0_first_err", 32'(ferr), 32'b1000110);
    check("sa0_pass", 32'(pass), 32'd0);
    check("sa0_done", 32'(done), 32'd1);
    fault4 = 1'b0;

    // Valid held high: one acceptance every S+2 clocks.
    do_reset();
    acc_q.delete();
    {aa, bb, cc} = 3'b000; last = 1'b0; vld = 1'b1;
    n = 0;
    while (acc_q.size() < 4 && n < 200) begin @(negedge clk); n++; end
    vld = 1'b0;
    if (acc_q.size() < 4) begin
      checks++; errors++; $display("FAIL throughput_timeout: %0d accepts", acc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) check("throughput_gap", 32'(acc_q[i+1] - acc_q[i]), 32'd6);
    end

    // Reset pulse during SETTLE of vector 3.
    do_reset();
    send(3'b011, 1'b0, 1'b1);
    send(3'b101, 1'b0, 1'b1);
    send(3'b111, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("abort_vec_cnt", 32'(vcnt), 32'd0);
    check("abort_rdy", 32'(rdy), 32'd1);
    send(3'b101, 1'b0, 1'b1);
    @(negedge clk);
    check("after_abort_vec_cnt", 32'(vcnt), 32'd1);
    check("after_abort_err_cnt", 32'(ecnt), 32'd0);

    // Saturation: CNT_W=2 instance, five mismatching vectors.
    do_reset();
    send_s(3'b001, 1'b0);
    send_s(3'b010, 1'b0);
    send_s(3'b011, 1'b0);
    send_s(3'b100, 1'b0);
    send_s(3'b101, 1'b1);
    repeat (2) @(negedge clk);
    check("sat_err_cnt", 32'(s_ecnt), 32'd3);
    check("sat_vec_cnt", 32'(s_vcnt), 32'd3);
    check("sat_first_err", 32'(s_ferr), 32'b0011110);
    check("sat_done", 32'(s_done), 32'd1);
    check("sat_pass", 32'(s_pass), 32'd0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
